// File: rtl/mux_conf_sequencer.sv
// Reconfiguration sequencer for top_design_mux: resets all designs, presents a new
// select, pulses the mux configuration clock with setup/hold, then releases one design.
module mux_conf_sequencer #(
    parameter int unsigned SELW        = 4,
    parameter int unsigned NDES        = 8,
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned CONF_CYCLES = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            i_req_valid,
    input  logic [SELW-1:0] i_req_sel,
    output logic            o_req_ready,
    output logic [SELW-1:0] o_mux_sel,
    output logic            o_mux_conf_clk,
    output logic [NDES-1:0] o_design_reset,
    output logic            o_busy,
    output logic            o_done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_SETUP   = 3'd2,
        ST_CLKHI   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    localparam logic [7:0] RST_LOAD  = 8'(RST_CYCLES - 1);
    localparam logic [7:0] CONF_LOAD = 8'(CONF_CYCLES - 1);

    state_t            state_r, state_s;
    logic [7:0]        cnt_r, cnt_s;
    logic [SELW-1:0]   sel_q_r, sel_q_s;
    logic [SELW-1:0]   mux_sel_r, mux_sel_s;
    logic              conf_clk_r, conf_clk_s;
    logic [NDES-1:0]   design_reset_r, design_reset_s;
    logic              ready_r, ready_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;

    // Selects out of range leave every design held in reset.
    function automatic logic [NDES-1:0] release_mask(input logic [SELW-1:0] sel);
        logic [NDES-1:0] mask;
        mask = {NDES{1'b1}};
        for (int i = 0; i < int'(NDES); i++) begin
            if (sel == SELW'(i)) begin
                mask[i] = 1'b0;
            end else begin
                mask[i] = mask[i];
            end
        end
        return mask;
    endfunction

    // State register and registered outputs, all cleared asynchronously.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 8'd0;
            sel_q_r        <= {SELW{1'b0}};
            mux_sel_r      <= {SELW{1'b0}};
            conf_clk_r     <= 1'b0;
            design_reset_r <= {NDES{1'b1}};
            ready_r        <= 1'b1;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            sel_q_r        <= sel_q_s;
            mux_sel_r      <= mux_sel_s;
            conf_clk_r     <= conf_clk_s;
            design_reset_r <= design_reset_s;
            ready_r        <= ready_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
        end
    end

    // Next-state and next-output logic; every output value is computed one edge ahead.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        sel_q_s        = sel_q_r;
        mux_sel_s      = mux_sel_r;
        conf_clk_s     = conf_clk_r;
        design_reset_s = design_reset_r;
        ready_s        = ready_r;
        done_s         = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (i_req_valid && ready_r) begin
                    sel_q_s        = i_req_sel;
                    cnt_s          = RST_LOAD;
                    design_reset_s = {NDES{1'b1}};
                    ready_s        = 1'b0;
                    state_s        = ST_ASSERT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (cnt_r == 8'd0) begin
                    cnt_s     = CONF_LOAD;
                    mux_sel_s = sel_q_r;
                    state_s   = ST_SETUP;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_SETUP: begin
                if (cnt_r == 8'd0) begin
                    cnt_s      = CONF_LOAD;
                    conf_clk_s = 1'b1;
                    state_s    = ST_CLKHI;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_CLKHI: begin
                if (cnt_r == 8'd0) begin
                    cnt_s      = CONF_LOAD;
                    conf_clk_s = 1'b0;
                    state_s    = ST_HOLD;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_r == 8'd0) begin
                    design_reset_s = release_mask(sel_q_r);
                    done_s         = 1'b1;
                    state_s        = ST_RELEASE;
                end else begin
                    cnt_s = cnt_r - 8'd1;
                end
            end
            ST_RELEASE: begin
                ready_s = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                // Unreachable encodings fall back to a safe idle with designs in reset.
                state_s        = ST_IDLE;
                conf_clk_s     = 1'b0;
                design_reset_s = {NDES{1'b1}};
                ready_s        = 1'b1;
            end
        endcase

        busy_s = ~ready_s;
    end

    assign o_req_ready    = ready_r;
    assign o_busy         = busy_r;
    assign o_done         = done_r;
    assign o_mux_sel      = mux_sel_r;
    assign o_mux_conf_clk = conf_clk_r;
    assign o_design_reset = design_reset_r;

endmodule

// File: tb/tb_mux_conf_sequencer.sv
// Bench for mux_conf_sequencer: timeline model checked every cycle on two parameter sets,
// plus directed literal checks at the cycles the sequence is defined by.
module tb_mux_conf_sequencer;

    localparam int RA = 16, CA = 4;
    localparam int RB = 1,  CB = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic [3:0] sel_a = 4'd0, sel_b = 4'd0;
    logic       ready_a, busy_a, conf_a, done_a, ready_b, busy_b, conf_b, done_b;
    logic [3:0] mux_a, mux_b;
    logic [7:0] dr_a, dr_b;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    mux_conf_sequencer dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .i_req_valid(valid_a), .i_req_sel(sel_a),
        .o_req_ready(ready_a), .o_mux_sel(mux_a), .o_mux_conf_clk(conf_a),
        .o_design_reset(dr_a), .o_busy(busy_a), .o_done(done_a)
    );

    mux_conf_sequencer #(.RST_CYCLES(RB), .CONF_CYCLES(CB)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .i_req_valid(valid_b), .i_req_sel(sel_b),
        .o_req_ready(ready_b), .o_mux_sel(mux_b), .o_mux_conf_clk(conf_b),
        .o_design_reset(dr_b), .o_busy(busy_b), .o_done(done_b)
    );

    // n = cycle index of the running sequence, 1 = cycle after the accept edge.
    typedef struct {
        bit         active;
        int         n;
        logic [3:0] sel;
        logic [3:0] mux;
        logic [7:0] dr;
    } mdl_t;

    mdl_t ma, mb;

    function automatic logic [7:0] relmask(input logic [3:0] s);
        logic [7:0] m;
        m = 8'hFF;
        if (s < 4'd8) m[s[2:0]] = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mreset();
        mdl_t m;
        m.active = 1'b0; m.n = 0; m.sel = 4'd0; m.mux = 4'd0; m.dr = 8'hFF;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic v, logic [3:0] s, int r, int c);
        mdl_t o;
        o = m;
        if (o.active) begin
            o.n++;
            if (o.n > r + 3 * c + 1) o.active = 1'b0;
        end else if (v) begin
            o.active = 1'b1;
            o.n = 1;
            o.sel = s;
        end
        if (o.active) begin
            if (o.n == r + 1) o.mux = o.sel;
            o.dr = (o.n == r + 3 * c + 1) ? relmask(o.sel) : 8'hFF;
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, valid_a, sel_a, RA, CA);
            mb <= mstep(mb, valid_b, sel_b, RB, CB);
        end
    end

    // Per-cycle comparison of both instances against the timeline model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_ready", ready_a, !ma.active);
            chk("a_busy", busy_a, ma.active);
            chk("a_conf", conf_a, ma.active && ma.n >= RA + CA + 1 && ma.n <= RA + 2 * CA);
            chk("a_done", done_a, ma.active && ma.n == RA + 3 * CA + 1);
            chk("a_mux", mux_a, ma.mux);
            chk("a_dr", dr_a, ma.dr);
            chk("b_ready", ready_b, !mb.active);
            chk("b_busy", busy_b, mb.active);
            chk("b_conf", conf_b, mb.active && mb.n >= RB + CB + 1 && mb.n <= RB + 2 * CB);
            chk("b_done", done_b, mb.active && mb.n == RB + 3 * CB + 1);
            chk("b_mux", mux_b, mb.mux);
            chk("b_dr", dr_b, mb.dr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done_a(input int maxc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (done_a) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("a_done_timeout", seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        bit seen;

        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_dr", dr_a, 8'hFF);
        chk("rst_mux", mux_a, 4'd0);
        chk("rst_conf", conf_a, 1'b0);
        chk("rst_ready", ready_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        rst = 1'b0;
        tick();

        // sel=3 with default timing
        valid_a = 1'b1; sel_a = 4'd3;
        tick();
        valid_a = 1'b0;
        busy_cnt = 0;
        for (int n = 1; n <= 30; n++) begin
            if (busy_a) busy_cnt++;
            if (n == 16) chk("s3_mux_c16", mux_a, 4'd0);
            if (n == 17) chk("s3_mux_c17", mux_a, 4'd3);
            if (n == 20) chk("s3_conf_c20", conf_a, 1'b0);
            if (n == 21) chk("s3_conf_c21", conf_a, 1'b1);
            if (n == 24) chk("s3_conf_c24", conf_a, 1'b1);
            if (n == 25) chk("s3_conf_c25", conf_a, 1'b0);
            if (n == 28) chk("s3_dr_c28", dr_a, 8'hFF);
            if (n == 29) begin
                chk("s3_dr_c29", dr_a, 8'hF7);
                chk("s3_done_c29", done_a, 1'b1);
                chk("s3_ready_c29", ready_a, 1'b0);
            end
            if (n == 30) begin
                chk("s3_ready_c30", ready_a, 1'b1);
                chk("s3_done_c30", done_a, 1'b0);
            end
            if (n < 30) tick();
        end
        chk("s3_busy_cycles", busy_cnt, 29);
        tick();

        // out-of-range select keeps every design in reset
        valid_a = 1'b1; sel_a = 4'd10;
        tick();
        valid_a = 1'b0;
        wait_done_a(60);
        chk("s10_mux", mux_a, 4'd10);
        chk("s10_dr", dr_a, 8'hFF);
        tick(); tick();

        // request held through a busy sequence
        valid_a = 1'b1; sel_a = 4'd2;
        tick();
        sel_a = 4'd5;
        wait_done_a(60);
        chk("s2_dr", dr_a, 8'hFB);
        tick();
        chk("s2_ready_release_edge", ready_a, 1'b1);
        tick();
        chk("s5_accepted", busy_a, 1'b1);
        valid_a = 1'b0;
        wait_done_a(60);
        chk("s5_dr", dr_a, 8'hDF);
        chk("s5_mux", mux_a, 4'd5);
        tick(); tick();

        // reset during the conf-clock high phase
        valid_a = 1'b1; sel_a = 4'd6;
        tick();
        valid_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (conf_a) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("s6_conf_high_reached", seen, 1'b1);
        chk("s6_mux_before_rst", mux_a, 4'd6);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_conf", conf_a, 1'b0);
        chk("mid_rst_dr", dr_a, 8'hFF);
        chk("mid_rst_mux", mux_a, 4'd0);
        chk("mid_rst_ready", ready_a, 1'b1);
        chk("mid_rst_done", done_a, 1'b0);
        tick();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (done_a) done_cnt++;
            tick();
        end
        chk("mid_rst_no_done", done_cnt, 0);
        valid_a = 1'b1; sel_a = 4'd1;
        tick();
        valid_a = 1'b0;
        wait_done_a(60);
        chk("s1_after_rst_dr", dr_a, 8'hFD);
        tick(); tick();

        // minimum phase lengths on instance B
        for (int rep = 0; rep < 2; rep++) begin
            valid_b = 1'b1; sel_b = 4'd4;
            tick();
            valid_b = 1'b0;
            busy_cnt = 0;
            for (int n = 1; n <= 6; n++) begin
                if (busy_b) busy_cnt++;
                if (n == 1) chk("b_dr_c1", dr_b, 8'hFF);
                if (n == 2) begin
                    chk("b_mux_c2", mux_b, 4'd4);
                    chk("b_conf_c2", conf_b, 1'b0);
                end
                if (n == 3) chk("b_conf_c3", conf_b, 1'b1);
                if (n == 4) begin
                    chk("b_conf_c4", conf_b, 1'b0);
                    chk("b_mux_c4", mux_b, 4'd4);
                end
                if (n == 5) begin
                    chk("b_done_c5", done_b, 1'b1);
                    chk("b_dr_c5", dr_b, 8'hEF);
                end
                if (n == 6) chk("b_ready_c6", ready_b, 1'b1);
                if (n < 6) tick();
            end
            chk("b_busy_cycles", busy_cnt, 5);
            tick();
        end

        tick(); tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
